cp0_exc_unit: RTL and testbench

Parametrised coprocessor-0 block for the OpenMIPS core: holds Count/Compare/Status/Cause/EPC/BadVAddr/Config/PRId and adds precise-exception entry, `eret` return, a Count prescaler, configurable hardware-interrupt width and a registered interrupt request. It sits beside the MEM/WB stage. MEM reports committed exceptions and `eret`, WB performs `mtc0`, and the `mfc0` read port serves the EX stage.

---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_timer.sv | 60 ++++++
 rtl/cp0_exc_unit.sv | 175 +++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers,
// exception codes and Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_BD     = 31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with a Count prescaler and the sticky timer interrupt flag.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_r;
    logic [31:0]   count_r;
    logic [31:0]   compare_r;
    logic          timer_r;
    logic          tick_s;
    logic          match_s;

    assign tick_s  = (presc_r == PRESC_LAST);
    assign match_s = (count_r == compare_r) && (compare_r != 32'd0);

    // Prescaler and Count: a software load restarts the prescale period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= {PW{1'b0}};
            count_r <= 32'd0;
        end else if (count_we) begin
            presc_r <= {PW{1'b0}};
            count_r <= wdata;
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
            count_r <= count_r + 32'd1;
        end else begin
            presc_r <= presc_r + PW'(1'b1);
        end
    end

    // Compare and sticky timer flag; a Compare write beats a same-cycle match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare_r <= 32'd0;
            timer_r   <= 1'b0;
        end else if (compare_we) begin
            compare_r <= wdata;
            timer_r   <= 1'b0;
        end else if (match_s) begin
            timer_r   <= 1'b1;
        end
    end

    assign count     = count_r;
    assign compare   = compare_r;
    assign timer_int = timer_r;

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file with precise exception entry, eret return,
// mtc0/mfc0 ports and a registered interrupt request.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          HW_INT_N     = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_WMASK = 32'h1000FF03,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
    parameter logic [31:0] PRID_VAL     = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL   = 32'h00008000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [4:0]          waddr_i,
    input  logic [31:0]         data_i,
    input  logic [4:0]          raddr_i,
    output logic [31:0]         data_o,
    input  logic [HW_INT_N-1:0] int_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_code_i,
    input  logic [31:0]         exc_pc_i,
    input  logic                exc_bd_i,
    input  logic [31:0]         exc_badvaddr_i,
    input  logic                eret_i,
    output logic [31:0]         count_o,
    output logic [31:0]         compare_o,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic [31:0]         badvaddr_o,
    output logic                timer_int_o,
    output logic                int_req_o,
    output logic [31:0]         exc_target_o
);
    logic [31:0] status_r, cause_r, epc_r, badvaddr_r;
    logic [31:0] status_nx_s, cause_nx_s, epc_nx_s, badvaddr_nx_s;
    logic [31:0] status_wr_s, cause_wr_s, wr_val_s, rd_s;
    logic [31:0] count_s, compare_s;
    logic        int_req_r, int_req_nx_s;
    logic        timer_int_s, mtc0_ok_s, writable_s, bypass_s;
    logic [5:0]  int_ext_s, hw_ip_s;

    // An exception or eret in the same cycle swallows the mtc0 completely.
    assign mtc0_ok_s = we_i && !exc_valid_i && !eret_i;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_ok_s && (waddr_i == CP0_COUNT)),
        .compare_we (mtc0_ok_s && (waddr_i == CP0_COMPARE)),
        .wdata      (data_i),
        .count      (count_s),
        .compare    (compare_s),
        .timer_int  (timer_int_s)
    );

    assign int_ext_s   = 6'(int_i);
    assign hw_ip_s     = {int_ext_s[5] | timer_int_s, int_ext_s[4:0]};
    assign status_wr_s = (data_i & STATUS_WMASK) | (status_r & ~STATUS_WMASK);
    assign cause_wr_s  = {cause_r[31:10], data_i[9:8], cause_r[7:0]};

    // Post-write value of the addressed register, used by both update and bypass.
    always_comb begin
        wr_val_s   = 32'd0;
        writable_s = 1'b1;
        case (waddr_i)
            CP0_STATUS:  wr_val_s = status_wr_s;
            CP0_CAUSE:   wr_val_s = cause_wr_s;
            CP0_COUNT,
            CP0_COMPARE,
            CP0_EPC:     wr_val_s = data_i;
            default:     writable_s = 1'b0;
        endcase
    end

    assign bypass_s = we_i && writable_s && (waddr_i == raddr_i);

    // Next state of the exception-related registers.
    always_comb begin
        status_nx_s   = status_r;
        cause_nx_s    = cause_r;
        epc_nx_s      = epc_r;
        badvaddr_nx_s = badvaddr_r;
        cause_nx_s[CA_IP_LO+7:CA_IP_LO+2] = hw_ip_s;
        if (exc_valid_i) begin
            cause_nx_s[CA_EXC_LO+4:CA_EXC_LO] = exc_code_i;
            status_nx_s[ST_EXL] = 1'b1;
            if (!status_r[ST_EXL]) begin
                epc_nx_s          = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                cause_nx_s[CA_BD] = exc_bd_i;
            end else begin
                epc_nx_s = epc_r;
            end
            if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)) begin
                badvaddr_nx_s = exc_badvaddr_i;
            end else begin
                badvaddr_nx_s = badvaddr_r;
            end
        end else if (eret_i) begin
            status_nx_s[ST_EXL] = 1'b0;
        end else if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_nx_s = status_wr_s;
                CP0_CAUSE:  cause_nx_s[CA_IP_LO+1:CA_IP_LO] = data_i[9:8];
                CP0_EPC:    epc_nx_s = data_i;
                default:    epc_nx_s = epc_r;
            endcase
        end else begin
            epc_nx_s = epc_r;
        end
    end

    // Request is withheld on the edge that takes an exception or eret.
    always_comb begin
        if (exc_valid_i || eret_i) begin
            int_req_nx_s = 1'b0;
        end else begin
            int_req_nx_s = status_r[ST_IE] && !status_r[ST_EXL] &&
                           (|(cause_r[CA_IP_LO+7:CA_IP_LO] & status_r[ST_IM_LO+7:ST_IM_LO]));
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_r   <= 32'd0;
            cause_r    <= 32'd0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
            int_req_r  <= 1'b0;
        end else begin
            status_r   <= status_nx_s;
            cause_r    <= cause_nx_s;
            epc_r      <= epc_nx_s;
            badvaddr_r <= badvaddr_nx_s;
            int_req_r  <= int_req_nx_s;
        end
    end

    // mfc0 read mux with same-cycle write bypass.
    always_comb begin
        rd_s = 32'd0;
        if (!rst) begin
            rd_s = 32'd0;
        end else if (bypass_s) begin
            rd_s = wr_val_s;
        end else begin
            case (raddr_i)
                CP0_BADVADDR: rd_s = badvaddr_r;
                CP0_COUNT:    rd_s = count_s;
                CP0_COMPARE:  rd_s = compare_s;
                CP0_STATUS:   rd_s = status_r;
                CP0_CAUSE:    rd_s = cause_r;
                CP0_EPC:      rd_s = epc_r;
                CP0_PRID:     rd_s = PRID_VAL;
                CP0_CONFIG:   rd_s = CONFIG_VAL;
                default:      rd_s = 32'd0;
            endcase
        end
    end

    assign data_o       = rd_s;
    assign exc_target_o = (eret_i && !exc_valid_i) ? epc_r : EXC_VECTOR;
    assign count_o      = count_s;
    assign compare_o    = compare_s;
    assign status_o     = status_r;
    assign cause_o      = cause_r;
    assign epc_o        = epc_r;
    assign badvaddr_o   = badvaddr_r;
    assign timer_int_o  = timer_int_s;
    assign int_req_o    = int_req_r;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed-vector bench for cp0_exc_unit with default parameters.
module tb_cp0_exc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [31:0] data_i = 32'd0;
    logic [4:0]  raddr_i = 5'd0;
    logic [31:0] data_o;
    logic [5:0]  int_i = 6'd0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = 5'd0;
    logic [31:0] exc_pc_i = 32'd0;
    logic        exc_bd_i = 1'b0;
    logic [31:0] exc_badvaddr_i = 32'd0;
    logic        eret_i = 1'b0;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, exc_target_o;
    logic        timer_int_o, int_req_o;
    int          n_vec = 0;
    int          n_err = 0;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .data_o(data_o), .int_i(int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .timer_int_o(timer_int_o), .int_req_o(int_req_o), .exc_target_o(exc_target_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic take_exc(input logic [4:0] code, input logic [31:0] pc,
                            input logic bd, input logic [31:0] bva);
        exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
        exc_bd_i = bd; exc_badvaddr_i = bva;
        tick();
        exc_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; raddr_i = 5'd15;
        #2;
        n_vec++; if (count_o !== 32'd0) begin n_err++; $display("FAIL reset_count got=%h exp=%h", count_o, 32'd0); end
        n_vec++; if (status_o !== 32'd0) begin n_err++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'd0); end
        n_vec++; if (data_o !== 32'd0) begin n_err++; $display("FAIL reset_read got=%h exp=%h", data_o, 32'd0); end
        n_vec++; if ({timer_int_o, int_req_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=%b", {timer_int_o, int_req_o}, 2'b00); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++; if (data_o !== 32'h004C0102) begin n_err++; $display("FAIL read_prid got=%h exp=%h", data_o, 32'h004C0102); end
        raddr_i = 5'd16; #1;
        n_vec++; if (data_o !== 32'h00008000) begin n_err++; $display("FAIL read_config got=%h exp=%h", data_o, 32'h00008000); end
        raddr_i = 5'd20; #1;
        n_vec++; if (data_o !== 32'd0) begin n_err++; $display("FAIL read_unmapped got=%h exp=%h", data_o, 32'd0); end
    endtask

    task automatic test_prescaler();
        repeat (10) tick();
        n_vec++; if (count_o !== 32'd5) begin n_err++; $display("FAIL prescale_count got=%h exp=%h", count_o, 32'd5); end
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFFFFFF; raddr_i = 5'd9; #1;
        n_vec++; if (data_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL count_bypass got=%h exp=%h", data_o, 32'hFFFFFFFF); end
        tick(); we_i = 1'b0;
        n_vec++; if (count_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL count_load got=%h exp=%h", count_o, 32'hFFFFFFFF); end
        tick();
        n_vec++; if (count_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL count_hold got=%h exp=%h", count_o, 32'hFFFFFFFF); end
        tick();
        n_vec++; if (count_o !== 32'd0) begin n_err++; $display("FAIL count_wrap got=%h exp=%h", count_o, 32'd0); end
    endtask

    task automatic test_timer();
        mtc0(5'd11, 32'd8);
        mtc0(5'd12, 32'h00008001);
        mtc0(5'd9, 32'd0);
        repeat (16) tick();
        n_vec++; if (count_o !== 32'd8) begin n_err++; $display("FAIL timer_count8 got=%h exp=%h", count_o, 32'd8); end
        n_vec++; if (timer_int_o !== 1'b0) begin n_err++; $display("FAIL timer_early got=%b exp=%b", timer_int_o, 1'b0); end
        tick();
        n_vec++; if (timer_int_o !== 1'b1) begin n_err++; $display("FAIL timer_set got=%b exp=%b", timer_int_o, 1'b1); end
        tick();
        n_vec++; if (cause_o !== 32'h00008000) begin n_err++; $display("FAIL timer_ip7 got=%h exp=%h", cause_o, 32'h00008000); end
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL timer_req_early got=%b exp=%b", int_req_o, 1'b0); end
        tick();
        n_vec++; if (int_req_o !== 1'b1) begin n_err++; $display("FAIL timer_req got=%b exp=%b", int_req_o, 1'b1); end
        mtc0(5'd11, 32'h20);
        n_vec++; if (timer_int_o !== 1'b0) begin n_err++; $display("FAIL timer_clear got=%b exp=%b", timer_int_o, 1'b0); end
        mtc0(5'd11, 32'd0);
        mtc0(5'd12, 32'd0);
        tick();
    endtask

    task automatic test_exception();
        exc_valid_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h1000; exc_bd_i = 1'b1;
        exc_badvaddr_i = 32'hDEAD; #1;
        n_vec++; if (exc_target_o !== 32'h40) begin n_err++; $display("FAIL exc_target got=%h exp=%h", exc_target_o, 32'h40); end
        tick(); exc_valid_i = 1'b0;
        n_vec++; if (epc_o !== 32'h0FFC) begin n_err++; $display("FAIL exc_epc_bd got=%h exp=%h", epc_o, 32'h0FFC); end
        n_vec++; if (cause_o !== 32'h80000030) begin n_err++; $display("FAIL exc_cause got=%h exp=%h", cause_o, 32'h80000030); end
        n_vec++; if (status_o !== 32'h2) begin n_err++; $display("FAIL exc_exl got=%h exp=%h", status_o, 32'h2); end
        n_vec++; if (badvaddr_o !== 32'd0) begin n_err++; $display("FAIL exc_bva_keep got=%h exp=%h", badvaddr_o, 32'd0); end
        take_exc(5'd12, 32'h2000, 1'b0, 32'd0);
        n_vec++; if (epc_o !== 32'h0FFC) begin n_err++; $display("FAIL nested_epc got=%h exp=%h", epc_o, 32'h0FFC); end
        n_vec++; if (cause_o !== 32'h80000030) begin n_err++; $display("FAIL nested_bd got=%h exp=%h", cause_o, 32'h80000030); end
    endtask

    task automatic test_adel();
        take_exc(5'd4, 32'h3000, 1'b0, 32'h80000003);
        n_vec++; if (badvaddr_o !== 32'h80000003) begin n_err++; $display("FAIL adel_bva got=%h exp=%h", badvaddr_o, 32'h80000003); end
        n_vec++; if (cause_o !== 32'h80000010) begin n_err++; $display("FAIL adel_cause got=%h exp=%h", cause_o, 32'h80000010); end
        take_exc(5'd8, 32'h3000, 1'b0, 32'h00001234);
        n_vec++; if (badvaddr_o !== 32'h80000003) begin n_err++; $display("FAIL sys_bva got=%h exp=%h", badvaddr_o, 32'h80000003); end
        n_vec++; if (epc_o !== 32'h0FFC) begin n_err++; $display("FAIL sys_epc got=%h exp=%h", epc_o, 32'h0FFC); end
    endtask

    task automatic test_simultaneous();
        eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF; #1;
        n_vec++; if (exc_target_o !== 32'h0FFC) begin n_err++; $display("FAIL eret_target got=%h exp=%h", exc_target_o, 32'h0FFC); end
        tick(); eret_i = 1'b0; we_i = 1'b0;
        n_vec++; if (status_o !== 32'd0) begin n_err++; $display("FAIL eret_drop_mtc0 got=%h exp=%h", status_o, 32'd0); end
        exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = 32'h3000; exc_bd_i = 1'b0; #1;
        n_vec++; if (exc_target_o !== 32'h40) begin n_err++; $display("FAIL both_target got=%h exp=%h", exc_target_o, 32'h40); end
        tick(); exc_valid_i = 1'b0; eret_i = 1'b0;
        n_vec++; if (status_o !== 32'h2) begin n_err++; $display("FAIL both_exl got=%h exp=%h", status_o, 32'h2); end
        raddr_i = 5'd14; #1;
        n_vec++; if (data_o !== 32'h3000) begin n_err++; $display("FAIL both_epc got=%h exp=%h", data_o, 32'h3000); end
    endtask

    task automatic test_wmask_bypass();
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF; raddr_i = 5'd12; #1;
        n_vec++; if (data_o !== 32'h1000FF03) begin n_err++; $display("FAIL status_bypass got=%h exp=%h", data_o, 32'h1000FF03); end
        tick(); we_i = 1'b0;
        n_vec++; if (status_o !== 32'h1000FF03) begin n_err++; $display("FAIL status_mask got=%h exp=%h", status_o, 32'h1000FF03); end
        we_i = 1'b1; waddr_i = 5'd13; raddr_i = 5'd13; #1;
        n_vec++; if (data_o !== 32'h00000300) begin n_err++; $display("FAIL cause_bypass got=%h exp=%h", data_o, 32'h00000300); end
        tick(); we_i = 1'b0;
        n_vec++; if (cause_o !== 32'h00000300) begin n_err++; $display("FAIL cause_mask got=%h exp=%h", cause_o, 32'h00000300); end
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL req_exl_block got=%b exp=%b", int_req_o, 1'b0); end
        eret_i = 1'b1; tick(); eret_i = 1'b0;
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL req_eret_edge got=%b exp=%b", int_req_o, 1'b0); end
        tick();
        n_vec++; if (int_req_o !== 1'b1) begin n_err++; $display("FAIL req_sw_ip got=%b exp=%b", int_req_o, 1'b1); end
    endtask

    task automatic test_hw_int();
        mtc0(5'd13, 32'd0);
        tick();
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL req_sw_clear got=%b exp=%b", int_req_o, 1'b0); end
        int_i = 6'b000100;
        tick();
        n_vec++; if (cause_o !== 32'h00001000) begin n_err++; $display("FAIL hw_ip4 got=%h exp=%h", cause_o, 32'h00001000); end
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL hw_req_early got=%b exp=%b", int_req_o, 1'b0); end
        tick();
        n_vec++; if (int_req_o !== 1'b1) begin n_err++; $display("FAIL hw_req got=%b exp=%b", int_req_o, 1'b1); end
        int_i = 6'b100000;
        tick();
        n_vec++; if (cause_o !== 32'h00008000) begin n_err++; $display("FAIL hw_ip7 got=%h exp=%h", cause_o, 32'h00008000); end
        int_i = 6'd0;
    endtask

    task automatic test_reset_mid();
        #2; rst = 1'b0; raddr_i = 5'd12; #1;
        n_vec++; if ({status_o, epc_o, cause_o} !== 96'd0) begin n_err++; $display("FAIL midreset_regs got=%h exp=%h", {status_o, epc_o, cause_o}, 96'd0); end
        n_vec++; if ({count_o, data_o} !== 64'd0) begin n_err++; $display("FAIL midreset_count got=%h exp=%h", {count_o, data_o}, 64'd0); end
        n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL midreset_req got=%b exp=%b", int_req_o, 1'b0); end
        rst = 1'b1;
        tick();
        n_vec++; if (count_o !== 32'd0) begin n_err++; $display("FAIL midreset_presc0 got=%h exp=%h", count_o, 32'd0); end
        tick();
        n_vec++; if (count_o !== 32'd1) begin n_err++; $display("FAIL midreset_presc1 got=%h exp=%h", count_o, 32'd1); end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_timer();
        test_exception();
        test_adel();
        test_simultaneous();
        test_wmask_bypass();
        test_hw_int();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
